// File: rtl/nes_pkg.sv
// Shared NES bus definitions: DMA engine states and fixed register addresses.
// Imported by the CPU/DMA bus master mux.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/cpu_dma_bus.sv
// Bus master mux between the CPU core and a block-copy DMA engine.
// A CPU write to TRIG_ADDR stalls the CPU and copies one page slice to DEST_ADDR.
module cpu_dma_bus
  import nes_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int XFER_LEN = 256,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = OAM_DMA_ADDR,
  parameter logic [ADDR_W-1:0] DEST_ADDR = OAMDATA_ADDR,
  parameter int ALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_r_w,
  input  logic [DATA_W-1:0] bus_din,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              r_w,
  output logic              cpu_rdy,
  output logic              dma_active
);

  localparam int IW = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam int OW = ADDR_W - DATA_W;
  localparam logic [IW-1:0] LAST = IW'(XFER_LEN - 1);

  dma_state_t        state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] page;
  logic [DATA_W-1:0] latch;
  logic              parity;
  logic              trig;
  logic [ADDR_W-1:0] src;

  assign trig = !cpu_r_w && (cpu_addr == TRIG_ADDR);
  assign src = {page, OW'(idx)};

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state  <= IDLE;
      idx    <= '0;
      page   <= '0;
      latch  <= '0;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      unique case (state)
        IDLE: begin
          if (trig) begin
            page  <= cpu_dout;
            state <= HALT;
          end
        end
        HALT: begin
          if ((ALIGN_EN != 0) && parity) state <= ALIGN;
          else                           state <= READ;
        end
        ALIGN: state <= READ;
        READ: begin
          latch <= bus_din;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces a read so nothing is written while the system comes up.
  always_comb begin
    addr = cpu_addr;
    dout = cpu_dout;
    r_w  = cpu_r_w;
    unique case (state)
      IDLE: ;
      HALT, ALIGN: r_w = 1'b1;
      READ: begin
        addr = src;
        r_w  = 1'b1;
      end
      WRITE: begin
        addr = DEST_ADDR;
        dout = latch;
        r_w  = 1'b0;
      end
      default: r_w = 1'b1;
    endcase
    if (!reset_l) r_w = 1'b1;
  end

  assign cpu_rdy    = (state == IDLE);
  assign dma_active = (state != IDLE);

endmodule
